// File: rtl/dq_burst_seq_if.sv
// rtl/dq_burst_seq_if.sv - command strobes in, DQ/DQS burst controls out
interface dq_burst_seq_if #(
  parameter int RANKS   = 2,
  parameter int BGWIDTH = 2,
  parameter int BAWIDTH = 2,
  parameter int CHIPS   = 16,
  parameter int BL      = 8
);
  localparam int RW = (RANKS > 1) ? $clog2(RANKS) : 1;
  localparam int BW = (BL > 1) ? $clog2(BL) : 1;

  logic [RANKS-1:0]   cs_n;
  logic               RD;
  logic               RDA;
  logic               WR;
  logic               WRA;
  logic [BGWIDTH-1:0] bg;
  logic [BAWIDTH-1:0] ba;

  logic               rd_en;
  logic               wr_capture;
  logic [BW-1:0]      beat;
  logic [RW-1:0]      burst_rank;
  logic [BGWIDTH-1:0] burst_bg;
  logic [BAWIDTH-1:0] burst_ba;
  logic               dqs_oe;
  logic [CHIPS-1:0]   dqs_t_o;
  logic [CHIPS-1:0]   dqs_c_o;
  logic               ap_done;
  logic               busy;
  logic               cmd_err;

  modport master (
    output cs_n, RD, RDA, WR, WRA, bg, ba,
    input  rd_en, wr_capture, beat, burst_rank, burst_bg, burst_ba,
           dqs_oe, dqs_t_o, dqs_c_o, ap_done, busy, cmd_err
  );

  modport slave (
    input  cs_n, RD, RDA, WR, WRA, bg, ba,
    output rd_en, wr_capture, beat, burst_rank, burst_bg, burst_ba,
           dqs_oe, dqs_t_o, dqs_c_o, ap_done, busy, cmd_err
  );
endinterface

// File: rtl/dq_burst_seq.sv
// rtl/dq_burst_seq.sv - latency-accurate DQ/DQS read/write burst sequencer
// Queues column commands with a due timestamp and plays them out as bursts.
module dq_burst_seq #(
  parameter int RANKS   = 2,
  parameter int BGWIDTH = 2,
  parameter int BAWIDTH = 2,
  parameter int CHIPS   = 16,
  parameter int BL      = 8,
  parameter int CL      = 22,
  parameter int CWL     = 16,
  parameter int RPRE    = 2,
  parameter int DEPTH   = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  dq_burst_seq_if.slave bus
);
  localparam int LMAX = (CL > CWL) ? CL : CWL;
  localparam int TW   = $clog2(LMAX + BL * (DEPTH + 1)) + 1;
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int RW   = (RANKS > 1) ? $clog2(RANKS) : 1;
  localparam int BW   = (BL > 1) ? $clog2(BL) : 1;

  localparam logic [TW-1:0]        CL_T    = TW'(CL);
  localparam logic [TW-1:0]        CWL_T   = TW'(CWL);
  localparam logic [TW-1:0]        BL_T    = TW'(BL);
  localparam logic [TW-1:0]        ONE_T   = TW'(1);
  localparam logic signed [TW-1:0] ZERO_S  = '0;
  localparam logic signed [TW-1:0] RPRE_S  = TW'(RPRE);
  localparam logic [BW-1:0]        BL_LAST = BW'(BL - 1);
  localparam logic [AW:0]          FULL_C  = (AW + 1)'(DEPTH);

  typedef struct packed {
    logic               rd;
    logic               ap;
    logic [RW-1:0]      rank;
    logic [BGWIDTH-1:0] bg;
    logic [BAWIDTH-1:0] ba;
    logic [TW-1:0]      due;
  } entry_t;

  typedef struct packed {
    logic               rd;
    logic               ap;
    logic [RW-1:0]      rank;
    logic [BGWIDTH-1:0] bg;
    logic [BAWIDTH-1:0] ba;
  } burst_t;

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_BURST} state_t;

  entry_t          fifo_q [DEPTH];
  logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [AW:0]     cnt_q, cnt_d;
  logic [TW-1:0]   now_q, now_n, last_end_q, last_end_d;
  logic            err_q, err_d;
  state_t          state_q, state_d;
  logic [BW-1:0]   beat_q, beat_d;
  burst_t          cur_q, cur_d;
  logic            ap_q, ap_d;

  logic [3:0]       strb;
  logic [RANKS-1:0] cs_low;
  logic             any_strb, accept, full, overlap, stale;
  logic             head_vld, due_now, pre_win, take, push, pop_fifo;
  entry_t           inc, head;
  logic signed [TW-1:0] head_dist;

  assign strb   = {bus.RD, bus.RDA, bus.WR, bus.WRA};
  assign cs_low = ~bus.cs_n;
  assign now_n  = now_q + ONE_T;

  // Command acceptance; cs_n is listed MSB-first, so bit RANKS-1 selects rank 0.
  always_comb begin
    inc      = '0;
    any_strb = |strb;
    inc.rd   = bus.RD | bus.RDA;
    inc.ap   = bus.RDA | bus.WRA;
    inc.bg   = bus.bg;
    inc.ba   = bus.ba;
    inc.due  = now_q + (inc.rd ? CL_T : CWL_T);
    for (int i = 0; i < RANKS; i++) begin
      if (cs_low[i]) inc.rank = RW'(RANKS - 1 - i);
    end
    full    = (cnt_q == FULL_C);
    overlap = ($signed(inc.due - last_end_q) < ZERO_S);
    stale   = ($signed(last_end_q - now_q) <= ZERO_S);
    err_d   = any_strb && (!$onehot(strb) || !$onehot(cs_low) || full || overlap);
    accept  = any_strb && !err_d;
    // An empty queue lets a just-accepted command be seen as head (short CWL).
    head_vld  = (cnt_q != '0) || accept;
    head      = (cnt_q != '0) ? fifo_q[rd_ptr_q] : inc;
    head_dist = $signed(head.due - now_n);
    due_now   = head_vld && (head_dist == ZERO_S);
    pre_win   = head_vld && head.rd && (head_dist > ZERO_S) && (head_dist <= RPRE_S);
  end

  // Next-state: decisions are made for the coming cycle (now_n).
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    cur_d   = cur_q;
    ap_d    = 1'b0;
    take    = 1'b0;
    case (state_q)
      S_BURST: begin
        if (beat_q != BL_LAST) begin
          beat_d = beat_q + BW'(1);
        end else begin
          ap_d = cur_q.ap;
          if (due_now)      take    = 1'b1;
          else if (pre_win) state_d = S_PRE;
          else              state_d = S_IDLE;
        end
      end
      default: begin
        if (due_now) begin
          take    = 1'b1;
          state_d = S_BURST;
        end else if (pre_win) begin
          state_d = S_PRE;
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
    if (take) begin
      beat_d = '0;
      cur_d  = '{rd: head.rd, ap: head.ap, rank: head.rank, bg: head.bg, ba: head.ba};
    end
  end

  assign pop_fifo = take && (cnt_q != '0);
  assign push     = accept && !(take && (cnt_q == '0));

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop_fifo})
      2'b10:   cnt_d = cnt_q + (AW + 1)'(1);
      2'b01:   cnt_d = cnt_q - (AW + 1)'(1);
      default: cnt_d = cnt_q;
    endcase
    // A stale last_end is pulled up to now so the modular compare never wraps.
    if (accept)     last_end_d = inc.due + BL_T;
    else if (stale) last_end_d = now_q;
    else            last_end_d = last_end_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      cur_q   <= '0;
      ap_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      cur_q   <= cur_d;
      ap_q    <= ap_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      now_q      <= '0;
      last_end_q <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      now_q      <= now_n;
      last_end_q <= last_end_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      if (push)     wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_fifo) rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= inc;
  end

  logic rd_beat;
  always_comb begin
    rd_beat        = (state_q == S_BURST) && cur_q.rd;
    bus.rd_en      = rd_beat;
    bus.wr_capture = (state_q == S_BURST) && !cur_q.rd;
    bus.dqs_oe     = (state_q == S_PRE) || rd_beat;
    bus.dqs_t_o    = {CHIPS{rd_beat && !beat_q[0]}};
    bus.dqs_c_o    = ~{CHIPS{rd_beat && !beat_q[0]}};
    bus.beat       = beat_q;
    bus.burst_rank = cur_q.rank;
    bus.burst_bg   = cur_q.bg;
    bus.burst_ba   = cur_q.ba;
    bus.ap_done    = ap_q;
    bus.cmd_err    = err_q;
    bus.busy       = (cnt_q != '0) || (state_q != S_IDLE);
  end
endmodule

// File: tb/tb_dq_burst_seq.sv
// tb/tb_dq_burst_seq.sv - scoreboard bench for dq_burst_seq
// Stimulus pushes per-cycle expectations; a negedge monitor pops and compares.
module tb_dq_burst_seq;
  localparam int RANKS = 2, BGW = 2, BAW = 2, CHIPS = 16, BL = 8;
  localparam int CL = 22, CWL = 16, RPRE = 2;
  // Two entries so the full condition is reachable with non-overlapping bursts.
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  dq_burst_seq_if #(.RANKS(RANKS), .BGWIDTH(BGW), .BAWIDTH(BAW), .CHIPS(CHIPS), .BL(BL)) bus ();

  dq_burst_seq #(
    .RANKS(RANKS), .BGWIDTH(BGW), .BAWIDTH(BAW), .CHIPS(CHIPS), .BL(BL),
    .CL(CL), .CWL(CWL), .RPRE(RPRE), .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  typedef struct {
    int cyc; bit rd; bit wr; bit oe; bit dqs; bit ap; bit err;
    int beat; int rank; int bg; int ba;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;

  always @(posedge clk) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  task automatic add_exp(input exp_t e);
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].cyc == e.cyc) begin
        sb[i].rd  = sb[i].rd  | e.rd;
        sb[i].wr  = sb[i].wr  | e.wr;
        sb[i].oe  = sb[i].oe  | e.oe;
        sb[i].dqs = sb[i].dqs | e.dqs;
        sb[i].ap  = sb[i].ap  | e.ap;
        sb[i].err = sb[i].err | e.err;
        if (e.rd || e.wr || e.ap) begin
          sb[i].beat = e.beat; sb[i].rank = e.rank; sb[i].bg = e.bg; sb[i].ba = e.ba;
        end
        return;
      end
      if (sb[i].cyc > e.cyc) begin
        sb.insert(i, e);
        return;
      end
    end
    sb.push_back(e);
  endtask

  task automatic chk(input string nm, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic at_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_inputs();
    bus.RD = 1'b0; bus.RDA = 1'b0; bus.WR = 1'b0; bus.WRA = 1'b0;
    bus.cs_n = '1; bus.bg = '0; bus.ba = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // s = {RD,RDA,WR,WRA}; ok = hand-decided acceptance; events at or after cut are not expected
  task automatic cmd(input int t, input logic [3:0] s, input logic [1:0] csn,
                     input int g, input int a, input bit ok, input int cut);
    exp_t e;
    bit   is_rd;
    int   lat;
    at_cyc(t);
    {bus.RD, bus.RDA, bus.WR, bus.WRA} = s;
    bus.cs_n = csn; bus.bg = g[BGW-1:0]; bus.ba = a[BAW-1:0];
    is_rd = s[3] | s[2];
    lat   = is_rd ? CL : CWL;
    if (ok) begin
      for (int b = 0; b < BL; b++) begin
        e = '{default: 0};
        e.cyc = t + lat + b; e.rd = is_rd; e.wr = !is_rd; e.oe = is_rd;
        e.dqs = is_rd && (b % 2 == 0); e.beat = b;
        e.rank = (csn == 2'b01) ? 0 : 1; e.bg = g; e.ba = a;
        if (e.cyc < cut) add_exp(e);
      end
      if (is_rd) begin
        for (int p = 1; p <= RPRE; p++) begin
          e = '{default: 0};
          e.cyc = t + lat - p; e.oe = 1'b1;
          if (e.cyc < cut) add_exp(e);
        end
      end
      if (s[2] | s[0]) begin
        e = '{default: 0};
        e.cyc = t + lat + BL; e.ap = 1'b1; e.bg = g; e.ba = a;
        if (e.cyc < cut) add_exp(e);
      end
    end else begin
      e = '{default: 0};
      e.cyc = t + 1; e.err = 1'b1;
      add_exp(e);
    end
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  exp_t m;
  bit   m_ok;
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      n_chk++; n_fail++;
      $display("FAIL missing_event at cyc=%0d (now cyc=%0d)", sb[0].cyc, cyc);
      void'(sb.pop_front());
    end
    if (bus.rd_en || bus.wr_capture || bus.dqs_oe || bus.ap_done || bus.cmd_err) begin
      n_chk++;
      if (sb.size() == 0 || sb[0].cyc != cyc) begin
        n_fail++;
        $display("FAIL unexpected_output cyc=%0d rd=%0b wr=%0b oe=%0b ap=%0b err=%0b",
                 cyc, bus.rd_en, bus.wr_capture, bus.dqs_oe, bus.ap_done, bus.cmd_err);
      end else begin
        m = sb.pop_front();
        m_ok = (bus.rd_en === m.rd) && (bus.wr_capture === m.wr) && (bus.dqs_oe === m.oe) &&
               (bus.dqs_t_o[0] === m.dqs) && (bus.ap_done === m.ap) && (bus.cmd_err === m.err);
        if (m.rd || m.wr)
          m_ok = m_ok && (int'(bus.beat) == m.beat) && (int'(bus.burst_rank) == m.rank);
        if (m.rd || m.wr || m.ap)
          m_ok = m_ok && (int'(bus.burst_bg) == m.bg) && (int'(bus.burst_ba) == m.ba);
        if (!m_ok) begin
          n_fail++;
          $display("FAIL cycle_vector cyc=%0d actual rd=%0b wr=%0b oe=%0b dqs=%0b ap=%0b err=%0b beat=%0d rank=%0d bg=%0d ba=%0d required rd=%0b wr=%0b oe=%0b dqs=%0b ap=%0b err=%0b beat=%0d rank=%0d bg=%0d ba=%0d",
                   cyc, bus.rd_en, bus.wr_capture, bus.dqs_oe, bus.dqs_t_o[0], bus.ap_done, bus.cmd_err,
                   bus.beat, bus.burst_rank, bus.burst_bg, bus.burst_ba,
                   m.rd, m.wr, m.oe, m.dqs, m.ap, m.err, m.beat, m.rank, m.bg, m.ba);
        end
      end
      n_chk++;
      if (bus.dqs_c_o !== ~bus.dqs_t_o || bus.dqs_t_o !== {CHIPS{bus.dqs_t_o[0]}}) begin
        n_fail++;
        $display("FAIL dqs_lanes cyc=%0d actual t=%h c=%h", cyc, bus.dqs_t_o, bus.dqs_c_o);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    chk("reset_rd_en", int'(bus.rd_en), 0);
    chk("reset_wr_capture", int'(bus.wr_capture), 0);
    chk("reset_dqs_oe", int'(bus.dqs_oe), 0);
    chk("reset_dqs_t", int'(bus.dqs_t_o), 0);
    chk("reset_dqs_c", int'(bus.dqs_c_o), 16'hffff);
    chk("reset_flags", int'({bus.ap_done, bus.busy, bus.cmd_err}), 0);
    chk("reset_burst_fields", int'({bus.beat, bus.burst_rank, bus.burst_bg, bus.burst_ba}), 0);

    // single read, rank 1
    at_cyc(10);
    chk("busy_before_read", int'(bus.busy), 0);
    cmd(10, 4'b1000, 2'b10, 2, 1, 1'b1, 1000);
    chk("busy_after_read", int'(bus.busy), 1);
    at_cyc(39); chk("busy_last_beat", int'(bus.busy), 1);
    at_cyc(40); chk("busy_after_burst", int'(bus.busy), 0);
    at_cyc(50); chk("sb_empty_read", sb.size(), 0);

    // WRA on rank 0 with auto-precharge report
    do_reset();
    cmd(10, 4'b0001, 2'b01, 1, 3, 1'b1, 1000);
    at_cyc(34);
    chk("ap_done_34", int'(bus.ap_done), 1);
    chk("ap_bank_34", int'({bus.burst_bg, bus.burst_ba}), 7);
    chk("busy_ap_cycle", int'(bus.busy), 0);
    at_cyc(50); chk("sb_empty_wra", sb.size(), 0);

    // seamless back-to-back reads
    do_reset();
    cmd(10, 4'b1000, 2'b10, 0, 0, 1'b1, 1000);
    cmd(18, 4'b1000, 2'b01, 1, 2, 1'b1, 1000);
    at_cyc(60); chk("sb_empty_seamless", sb.size(), 0);

    // truncated preamble: one-cycle gap between reads
    do_reset();
    cmd(10, 4'b1000, 2'b10, 0, 0, 1'b1, 1000);
    cmd(19, 4'b1000, 2'b10, 3, 3, 1'b1, 1000);
    at_cyc(60); chk("sb_empty_trunc_pre", sb.size(), 0);

    // rejects: overlap, bad cs_n, two strobes; then a later legal read
    do_reset();
    cmd(10, 4'b1000, 2'b10, 0, 1, 1'b1, 1000);
    cmd(15, 4'b1000, 2'b10, 0, 2, 1'b0, 1000);
    cmd(50, 4'b1000, 2'b00, 0, 0, 1'b0, 1000);
    cmd(60, 4'b1010, 2'b10, 0, 0, 1'b0, 1000);
    cmd(65, 4'b0010, 2'b11, 0, 0, 1'b0, 1000);
    cmd(70, 4'b1000, 2'b01, 2, 2, 1'b1, 1000);
    at_cyc(110); chk("sb_empty_rejects", sb.size(), 0);

    // queue full rejects the third read; a read after the first pop is accepted
    do_reset();
    cmd(10, 4'b1000, 2'b10, 0, 0, 1'b1, 1000);
    cmd(18, 4'b1000, 2'b10, 1, 1, 1'b1, 1000);
    cmd(26, 4'b1000, 2'b10, 2, 2, 1'b0, 1000);
    cmd(35, 4'b0100, 2'b01, 3, 0, 1'b1, 1000);
    at_cyc(80); chk("sb_empty_full", sb.size(), 0);

    // reset asserted mid-burst
    do_reset();
    cmd(10, 4'b1000, 2'b10, 1, 1, 1'b1, 35);
    at_cyc(35);
    reset_n = 1'b0;
    #1;
    chk("async_reset_rd_en", int'(bus.rd_en), 0);
    chk("async_reset_dqs_oe", int'(bus.dqs_oe), 0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    at_cyc(1);
    chk("busy_after_release", int'(bus.busy), 0);
    at_cyc(40);
    chk("sb_empty_reset", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
